// File: rtl/mp_banked_ram_if.sv
// Request/response bundle for the N-port banked RAM.
// Port p occupies bit p of the scalar vectors and slice [32p+:32] / [4p+:4] of the wide ones.
interface mp_banked_ram_if #(
  parameter int unsigned N_PORTS = 2
);
  logic [N_PORTS-1:0]    req_i;
  logic [N_PORTS-1:0]    gnt_o;
  logic [N_PORTS-1:0]    rvalid_o;
  logic [N_PORTS*32-1:0] addr_i;
  logic [N_PORTS-1:0]    we_i;
  logic [N_PORTS*4-1:0]  be_i;
  logic [N_PORTS*32-1:0] wdata_i;
  logic [N_PORTS*32-1:0] rdata_o;
  logic [N_PORTS-1:0]    err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/mp_banked_ram.sv
// N-port word-interleaved banked RAM with per-bank round-robin arbitration,
// byte enables, out-of-range error responses and flag/result capture registers.
module mp_banked_ram #(
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned N_BANKS     = 2,
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter logic [31:0] FLAG_ADDR   = 32'h0000_FFF8,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_FFFC
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mp_banked_ram_if.slave      bus,
  output logic [31:0]         mem_flag_o,
  output logic [31:0]         mem_result_o
);

  localparam int unsigned ROWS   = DEPTH_WORDS / N_BANKS;
  localparam int unsigned LOG2B  = $clog2(N_BANKS);
  localparam int unsigned BANK_W = (N_BANKS > 1) ? LOG2B : 1;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [29:0] FLAG_WORD   = FLAG_ADDR[31:2];
  localparam logic [29:0] RESULT_WORD = RESULT_ADDR[31:2];

  logic [29:0]         w_word  [N_PORTS];
  logic [BANK_W-1:0]   w_bank  [N_PORTS];
  logic [ROW_W-1:0]    w_row   [N_PORTS];
  logic [31:0]         w_wdata [N_PORTS];
  logic [3:0]          w_be    [N_PORTS];
  logic [N_PORTS-1:0]  w_inr;
  logic [2*N_PORTS-1:0] w_addr_unused;

  logic [PTR_W-1:0]    r_rr    [N_BANKS];
  logic [PTR_W-1:0]    w_win   [N_BANKS];
  logic [N_BANKS-1:0]  w_hit;
  logic [PTR_W-1:0]    w_idx;
  logic [N_PORTS-1:0]  w_gnt;
  logic [31:0]         w_bank_rdata [N_BANKS];

  logic [N_PORTS-1:0]  r_rvalid;
  logic [N_PORTS-1:0]  r_err;
  logic [31:0]         r_rdata [N_PORTS];
  logic [N_PORTS*32-1:0] w_rdata_flat;
  logic [31:0]         r_flag;
  logic [31:0]         r_result;

  // Per-port address decode: bank from the low word bits, row from the rest.
  always_comb begin
    w_inr         = '0;
    w_addr_unused = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      w_word[p]  = bus.addr_i[32*p+2 +: 30];
      w_addr_unused[2*p +: 2] = bus.addr_i[32*p +: 2];
      w_bank[p]  = BANK_W'(w_word[p] % N_BANKS);
      w_row[p]   = ROW_W'(w_word[p] >> LOG2B);
      w_inr[p]   = {2'b00, w_word[p]} < DEPTH_WORDS;
      w_wdata[p] = bus.wdata_i[32*p +: 32];
      w_be[p]    = bus.be_i[4*p +: 4];
    end
  end

  // Per-bank round-robin: first in-range requester at or after r_rr[b], cyclic.
  always_comb begin
    w_hit = '0;
    w_idx = '0;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      w_win[b] = '0;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
        w_idx = PTR_W'((32'(r_rr[b]) + k) % N_PORTS);
        if (!w_hit[b] && bus.req_i[w_idx] && w_inr[w_idx] &&
            (w_bank[w_idx] == BANK_W'(b))) begin
          w_hit[b] = 1'b1;
          w_win[b] = w_idx;
        end
      end
    end
  end

  // Out-of-range requests bypass the banks and are granted unconditionally.
  always_comb begin
    w_gnt = bus.req_i & ~w_inr;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      if (w_hit[b]) begin
        w_gnt[w_win[b]] = 1'b1;
      end
    end
    if (!rst_ni) begin
      w_gnt = '0;
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [31:0]      r_mem [ROWS];
    logic [ROW_W-1:0] w_brow;
    logic             w_bwe;

    assign w_brow          = w_row[w_win[b]];
    assign w_bwe           = rst_ni && w_hit[b] && bus.we_i[w_win[b]];
    assign w_bank_rdata[b] = r_mem[w_brow];

    always_ff @(posedge clk_i) begin
      if (w_bwe) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (w_be[w_win[b]][i]) begin
            r_mem[w_brow][8*i +: 8] <= w_wdata[w_win[b]][8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rvalid <= '0;
      r_err    <= '0;
      r_flag   <= '0;
      r_result <= '0;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        r_rdata[p] <= '0;
      end
      for (int unsigned b = 0; b < N_BANKS; b++) begin
        r_rr[b] <= '0;
      end
    end else begin
      r_rvalid <= w_gnt;
      for (int unsigned b = 0; b < N_BANKS; b++) begin
        if (w_hit[b]) begin
          r_rr[b] <= PTR_W'((32'(w_win[b]) + 1) % N_PORTS);
        end
      end
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (w_gnt[p]) begin
          r_err[p]   <= !w_inr[p];
          r_rdata[p] <= (w_inr[p] && !bus.we_i[p]) ? w_bank_rdata[w_bank[p]] : '0;
        end
        // Capture registers shadow the RAM word; the RAM itself is still written.
        if (w_gnt[p] && w_inr[p] && bus.we_i[p]) begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (w_be[p][i]) begin
              if (w_word[p] == FLAG_WORD) begin
                r_flag[8*i +: 8] <= w_wdata[p][8*i +: 8];
              end
              if (w_word[p] == RESULT_WORD) begin
                r_result[8*i +: 8] <= w_wdata[p][8*i +: 8];
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_rdata_flat = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      w_rdata_flat[32*p +: 32] = r_rdata[p];
    end
  end

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.err_o    = r_err;
  assign bus.rdata_o  = w_rdata_flat;
  assign mem_flag_o   = r_flag;
  assign mem_result_o = r_result;

endmodule

// File: tb/tb_mp_banked_ram.sv
// Directed-vector bench for mp_banked_ram with two ports and two banks.
module tb_mp_banked_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] flag;
  logic [31:0] result;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mp_banked_ram_if #(.N_PORTS(2)) bus ();

  mp_banked_ram #(
    .N_PORTS(2),
    .N_BANKS(2),
    .DEPTH_WORDS(16384),
    .FLAG_ADDR(32'h0000_FFF8),
    .RESULT_ADDR(32'h0000_FFFC)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus),
    .mem_flag_o(flag),
    .mem_result_o(result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic [31:0] a,
                          input logic w, input logic [3:0] be, input logic [31:0] d);
    bus.req_i[p]           = r;
    bus.addr_i[32*p +: 32] = a;
    bus.we_i[p]            = w;
    bus.be_i[4*p +: 4]     = be;
    bus.wdata_i[32*p +: 32] = d;
  endtask

  task automatic idle();
    set_port(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_port(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_port(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
    set_port(1, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
    repeat (2) tick();
    #4;
    checks++;
    if (bus.gnt_o !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt_o);
    end
    checks++;
    if (bus.rvalid_o !== 2'b00 || bus.err_o !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid_err: got %b/%b expected 00/00", bus.rvalid_o, bus.err_o);
    end
    checks++;
    if (bus.rdata_o !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata_o);
    end
    checks++;
    if (flag !== 32'h0 || result !== 32'h0) begin
      errors++; $display("FAIL reset_flag_result: got %h/%h expected 0/0", flag, result);
    end
    idle();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    set_port(0, 1'b1, 32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    #4;
    checks++;
    if (bus.gnt_o !== 2'b01) begin
      errors++; $display("FAIL wr_gnt: got %b expected 01", bus.gnt_o);
    end
    tick();
    checks++;
    if (bus.rvalid_o !== 2'b01 || bus.err_o[0] !== 1'b0 || bus.rdata_o[31:0] !== 32'h0) begin
      errors++; $display("FAIL wr_resp: rvalid %b err %b rdata %h expected 01 0 0",
                         bus.rvalid_o, bus.err_o[0], bus.rdata_o[31:0]);
    end
    set_port(0, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
    #4;
    checks++;
    if (bus.gnt_o !== 2'b01) begin
      errors++; $display("FAIL rd_gnt: got %b expected 01", bus.gnt_o);
    end
    tick();
    checks++;
    if (bus.rvalid_o !== 2'b01 || bus.err_o[0] !== 1'b0 || bus.rdata_o[31:0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_resp: rvalid %b err %b rdata %h expected 01 0 deadbeef",
                         bus.rvalid_o, bus.err_o[0], bus.rdata_o[31:0]);
    end
    idle();
    tick();
    checks++;
    if (bus.rvalid_o !== 2'b00 || bus.rdata_o[31:0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_hold: rvalid %b rdata %h expected 00 deadbeef",
                         bus.rvalid_o, bus.rdata_o[31:0]);
    end
  endtask

  task automatic test_byte_enable();
    set_port(0, 1'b1, 32'h200, 1'b1, 4'hF, 32'hFFFF_FFFF);
    tick();
    set_port(0, 1'b1, 32'h200, 1'b1, 4'b0101, 32'h1122_3344);
    tick();
    set_port(0, 1'b1, 32'h200, 1'b0, 4'hF, 32'h0);
    tick();
    checks++;
    if (bus.rvalid_o[0] !== 1'b1 || bus.rdata_o[31:0] !== 32'hFF22_FF44) begin
      errors++; $display("FAIL byte_enable: rvalid %b rdata %h expected 1 ff22ff44",
                         bus.rvalid_o[0], bus.rdata_o[31:0]);
    end
    idle();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [4];
    int cnt0;
    int cnt1;
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    cnt0 = 0;
    cnt1 = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_port(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
    set_port(1, 1'b1, 32'h8, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #4;
      checks++;
      if (bus.gnt_o !== exp_gnt[i]) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, bus.gnt_o, exp_gnt[i]);
      end
      tick();
      cnt0 += int'(bus.rvalid_o[0]);
      cnt1 += int'(bus.rvalid_o[1]);
    end
    idle();
    checks++;
    if (cnt0 != 2 || cnt1 != 2) begin
      errors++; $display("FAIL rr_rvalid_count: got %0d/%0d expected 2/2", cnt0, cnt1);
    end
    tick();
  endtask

  task automatic test_parallel_banks();
    set_port(0, 1'b1, 32'h0, 1'b1, 4'hF, 32'hA5A5_A5A5);
    set_port(1, 1'b1, 32'h4, 1'b1, 4'hF, 32'h5A5A_5A5A);
    #4;
    checks++;
    if (bus.gnt_o !== 2'b11) begin
      errors++; $display("FAIL par_wr_gnt: got %b expected 11", bus.gnt_o);
    end
    tick();
    checks++;
    if (bus.rvalid_o !== 2'b11 || bus.err_o !== 2'b00) begin
      errors++; $display("FAIL par_wr_resp: rvalid %b err %b expected 11 00", bus.rvalid_o, bus.err_o);
    end
    set_port(0, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
    set_port(1, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
    #4;
    checks++;
    if (bus.gnt_o !== 2'b11) begin
      errors++; $display("FAIL par_rd_gnt: got %b expected 11", bus.gnt_o);
    end
    tick();
    checks++;
    if (bus.rvalid_o !== 2'b11 || bus.rdata_o !== {32'hA5A5_A5A5, 32'h5A5A_5A5A}) begin
      errors++; $display("FAIL par_rd_data: rvalid %b rdata %h expected 11 a5a5a5a55a5a5a5a",
                         bus.rvalid_o, bus.rdata_o);
    end
    idle();
    tick();
  endtask

  task automatic test_out_of_range();
    set_port(0, 1'b1, 32'h0001_0000, 1'b1, 4'hF, 32'h1234_5678);
    set_port(1, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
    #4;
    checks++;
    if (bus.gnt_o !== 2'b11) begin
      errors++; $display("FAIL oor_wr_gnt: got %b expected 11", bus.gnt_o);
    end
    tick();
    checks++;
    if (bus.rvalid_o !== 2'b11 || bus.err_o !== 2'b01 ||
        bus.rdata_o !== {32'hA5A5_A5A5, 32'h0}) begin
      errors++; $display("FAIL oor_wr_resp: rvalid %b err %b rdata %h expected 11 01 a5a5a5a500000000",
                         bus.rvalid_o, bus.err_o, bus.rdata_o);
    end
    set_port(0, 1'b1, 32'h0001_0000, 1'b0, 4'hF, 32'h0);
    set_port(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #4;
    checks++;
    if (bus.gnt_o !== 2'b01) begin
      errors++; $display("FAIL oor_rd_gnt: got %b expected 01", bus.gnt_o);
    end
    tick();
    checks++;
    if (bus.rvalid_o[0] !== 1'b1 || bus.err_o[0] !== 1'b1 || bus.rdata_o[31:0] !== 32'h0) begin
      errors++; $display("FAIL oor_rd_resp: rvalid %b err %b rdata %h expected 1 1 0",
                         bus.rvalid_o[0], bus.err_o[0], bus.rdata_o[31:0]);
    end
    set_port(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
    tick();
    checks++;
    if (bus.err_o[0] !== 1'b0 || bus.rdata_o[31:0] !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL oor_ram_intact: err %b rdata %h expected 0 a5a5a5a5",
                         bus.err_o[0], bus.rdata_o[31:0]);
    end
    idle();
    tick();
  endtask

  task automatic test_flag_result_reset();
    set_port(0, 1'b1, 32'h0000_FFF8, 1'b1, 4'hF, 32'h1);
    tick();
    checks++;
    if (flag !== 32'h1 || result !== 32'h0) begin
      errors++; $display("FAIL flag_write: flag %h result %h expected 1 0", flag, result);
    end
    set_port(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_port(1, 1'b1, 32'h0000_FFFC, 1'b1, 4'hF, 32'h2A);
    tick();
    checks++;
    if (result !== 32'h2A || flag !== 32'h1) begin
      errors++; $display("FAIL result_write: flag %h result %h expected 1 2a", flag, result);
    end
    set_port(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_port(0, 1'b1, 32'h0000_FFF8, 1'b1, 4'b0010, 32'hAABB_CCDD);
    tick();
    checks++;
    if (flag !== 32'h0000_CC01) begin
      errors++; $display("FAIL flag_byte: got %h expected 0000cc01", flag);
    end
    set_port(0, 1'b1, 32'h0000_FFF8, 1'b0, 4'hF, 32'h0);
    tick();
    checks++;
    if (bus.rdata_o[31:0] !== 32'h0000_CC01) begin
      errors++; $display("FAIL flag_ram_read: got %h expected 0000cc01", bus.rdata_o[31:0]);
    end
    set_port(0, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
    tick();
    checks++;
    if (bus.rvalid_o[0] !== 1'b1 || bus.rdata_o[31:0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL pre_reset_read: rvalid %b rdata %h expected 1 deadbeef",
                         bus.rvalid_o[0], bus.rdata_o[31:0]);
    end
    rst_n = 1'b0;
    set_port(0, 1'b1, 32'h100, 1'b1, 4'hF, 32'h0BAD_F00D);
    #4;
    checks++;
    if (bus.gnt_o !== 2'b00) begin
      errors++; $display("FAIL reset_cycle_gnt: got %b expected 00", bus.gnt_o);
    end
    tick();
    rst_n = 1'b1;
    idle();
    checks++;
    if (bus.rvalid_o !== 2'b00 || bus.rdata_o !== 64'h0 || flag !== 32'h0 || result !== 32'h0) begin
      errors++; $display("FAIL reset_clear: rvalid %b rdata %h flag %h result %h expected 00 0 0 0",
                         bus.rvalid_o, bus.rdata_o, flag, result);
    end
    set_port(0, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
    tick();
    checks++;
    if (bus.rvalid_o[0] !== 1'b1 || bus.rdata_o[31:0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_preserved: rvalid %b rdata %h expected 1 deadbeef",
                         bus.rvalid_o[0], bus.rdata_o[31:0]);
    end
    idle();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_byte_enable();
    test_round_robin();
    test_parallel_banks();
    test_out_of_range();
    test_flag_result_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
